// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-stage types and bubble constants.
//   pipe_occ_e     : occupancy state of an elastic stage (EMPTY / BUSY / FULL)
//   occ_count()    : maps the occupancy state onto the 0/1/2 entry count
//   id_ex_reg_t    : example stage payload carried through pipe_skid_stage
//   ID_EX_BUBBLE   : bubble pattern used as RESET_VAL for that payload
package pipe_skid_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 8;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // Encoding chosen so the state value is directly the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_BUSY  = 2'd1,
        OCC_FULL  = 2'd2
    } pipe_occ_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } id_ex_reg_t;

    localparam id_ex_reg_t ID_EX_BUBBLE = '{pc: RESET_PC, ctrl: '0, valid: 1'b0};

    // Number of payload entries held in a given occupancy state.
    function automatic logic [1:0] occ_count(input pipe_occ_e occ);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (occ)
            OCC_EMPTY: cnt = 2'd0;
            OCC_BUSY:  cnt = 2'd1;
            OCC_FULL:  cnt = 2'd2;
            default:   cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage carrying a DATA_W-bit payload.
// Replaces fixed stall/flush stage registers; stall is out_ready=0, flush
// inserts a bubble. With SKID=1 a second (skid) entry lets in_ready come
// straight from a flop, cutting the backward ready path while keeping
// one transfer per cycle.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high, highest priority
//   flush      : synchronous bubble insert, below reset
//   in_valid   : upstream payload valid
//   in_ready   : stage accepts payload this cycle
//   in_data    : upstream payload
//   out_valid  : downstream payload valid
//   out_ready  : downstream accepts (0 = stall)
//   out_data   : payload to downstream (main register)
//   occupancy  : entries held, 0/1/2
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned       DATA_W         = 64,
    parameter logic [DATA_W-1:0] RESET_VAL      = '0,
    parameter bit                SKID           = 1'b1,
    parameter bit                CLEAR_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_occ_e         state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q;
    logic              skid_load_c;
    logic              in_fire_c;
    logic              out_fire_c;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // Outputs are decodes of the state / main registers.
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_count(state_q);

    // Next-state and main-register update.
    // A flush drops whatever is offered and empties the stage; if out_fire
    // coincides, downstream has already taken main this cycle.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_load_c = 1'b0;

        if (flush) begin
            state_d = OCC_EMPTY;
            main_d  = RESET_VAL;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_fire_c) begin
                        state_d = OCC_BUSY;
                        main_d  = in_data;
                    end
                end
                OCC_BUSY: begin
                    if (in_fire_c && out_fire_c) begin
                        main_d = in_data;
                    end else if (in_fire_c) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d     = OCC_FULL;
                        skid_load_c = 1'b1;
                    end else if (out_fire_c) begin
                        state_d = OCC_EMPTY;
                        if (CLEAR_ON_EMPTY) begin
                            main_d = RESET_VAL;
                        end
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here; only draining is possible.
                    if (out_fire_c) begin
                        state_d = OCC_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                    main_d  = RESET_VAL;
                end
            endcase
        end
    end

    // State and main payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            main_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    if (SKID) begin : g_skid
        logic [DATA_W-1:0] skid_d;
        logic              in_ready_q;
        logic              in_ready_d;

        // Skid entry: loaded only on a stalled accept, cleared by flush.
        always_comb begin
            skid_d = skid_q;
            if (flush) begin
                skid_d = RESET_VAL;
            end else if (skid_load_c) begin
                skid_d = in_data;
            end
        end

        // Ready for next cycle depends only on next state, never on out_ready
        // within the same cycle.
        always_comb begin
            in_ready_d = (state_d != OCC_FULL);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                skid_q     <= RESET_VAL;
                in_ready_q <= 1'b1;
            end else begin
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_no_skid
        logic unused_skid_load;

        // Single-entry stage: FULL is unreachable, so skid content is a constant.
        assign skid_q           = RESET_VAL;
        assign unused_skid_load = skid_load_c;

        // Accept when empty or when main is leaving this cycle.
        assign in_ready = ~out_valid | out_ready;
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: one SKID=1/CLEAR_ON_EMPTY=1 instance and
// one SKID=0/CLEAR_ON_EMPTY=0 instance, both DATA_W=32, RESET_VAL=32'h13,
// followed by a short valid/ready scoreboard run on each.
module tb_pipe_skid_stage;

    localparam int unsigned     DW   = 32;
    localparam logic [DW-1:0]   RV   = 32'h0000_0013;

    logic          clk;
    logic          reset;

    logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [DW-1:0] in_data1, out_data1;
    logic [1:0]    occ1;

    logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0]    occ0;

    int checks = 0;
    int errors = 0;

    pipe_skid_stage #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b1), .CLEAR_ON_EMPTY(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_skid_stage #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b0), .CLEAR_ON_EMPTY(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves time just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Empty-stage check for the SKID=1 instance.
    task automatic chk_empty1(input string tag);
        chk({tag, ".out_valid"}, DW'(out_valid1), DW'(1'b0));
        chk({tag, ".out_data"},  out_data1,       RV);
        chk({tag, ".occ"},       DW'(occ1),       DW'(2'd0));
        chk({tag, ".in_ready"},  DW'(in_ready1),  DW'(1'b1));
    endtask

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] seq1, seq0, exp_v;
    logic          fi1, fo1, fi0, fo0;

    initial begin
        reset = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;

        // 1: reset held for two cycles
        tick(); tick();
        chk_empty1("rst1");
        chk("rst0.out_valid", DW'(out_valid0), DW'(1'b0));
        chk("rst0.out_data",  out_data0,       RV);
        chk("rst0.occ",       DW'(occ0),       DW'(2'd0));
        chk("rst0.in_ready",  DW'(in_ready0),  DW'(1'b1));
        reset = 1'b0;

        // 2: streaming 1..4 at full rate
        out_ready1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid1 = 1'b1;
            in_data1  = DW'(i);
            tick();
            chk($sformatf("stream%0d.data", i), out_data1,       DW'(i));
            chk($sformatf("stream%0d.vld", i),  DW'(out_valid1), DW'(1'b1));
            chk($sformatf("stream%0d.rdy", i),  DW'(in_ready1),  DW'(1'b1));
            chk($sformatf("stream%0d.occ", i),  DW'(occ1),       DW'(2'd1));
        end
        in_valid1 = 1'b0;
        tick();
        chk_empty1("stream_drain");

        // 3: skid fill under stall, then in-order drain
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 32'h0000_00A0;
        tick();
        chk("skidA.data", out_data1,      32'h0000_00A0);
        chk("skidA.rdy",  DW'(in_ready1), DW'(1'b1));
        in_data1 = 32'h0000_00B0;
        tick();
        chk("skidB.occ",  DW'(occ1),      DW'(2'd2));
        chk("skidB.rdy",  DW'(in_ready1), DW'(1'b0));
        chk("skidB.data", out_data1,      32'h0000_00A0);
        in_data1 = 32'h0000_00C0;
        tick();
        chk("skidC_held.occ",  DW'(occ1), DW'(2'd2));
        chk("skidC_held.data", out_data1, 32'h0000_00A0);
        out_ready1 = 1'b1;
        tick();
        chk("drainB.data", out_data1,      32'h0000_00B0);
        chk("drainB.occ",  DW'(occ1),      DW'(2'd1));
        chk("drainB.rdy",  DW'(in_ready1), DW'(1'b1));
        tick();
        chk("drainC.data", out_data1, 32'h0000_00C0);
        chk("drainC.occ",  DW'(occ1), DW'(2'd1));
        in_valid1 = 1'b0;
        tick();
        chk_empty1("drain_end");

        // 4: flush while FULL under stall
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 32'h0000_00A1;
        tick();
        in_data1 = 32'h0000_00B1;
        tick();
        chk("flushfull.occ_pre", DW'(occ1), DW'(2'd2));
        in_valid1 = 1'b0; flush1 = 1'b1;
        tick();
        flush1 = 1'b0;
        chk_empty1("flushfull");
        out_ready1 = 1'b1;
        tick();
        chk("flushfull.after", DW'(out_valid1), DW'(1'b0));

        // 5: flush with offered D and out_fire on A
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 32'h0000_00A2;
        tick();
        flush1 = 1'b1; out_ready1 = 1'b1; in_data1 = 32'h0000_00D2;
        #1;
        chk("flushfire.A_vld",  DW'(out_valid1), DW'(1'b1));
        chk("flushfire.A_data", out_data1,       32'h0000_00A2);
        tick();
        flush1 = 1'b0; in_valid1 = 1'b0;
        chk_empty1("flushfire");
        tick();
        chk("flushfire.D_dropped", DW'(out_valid1), DW'(1'b0));

        // reset and flush together behave as reset
        in_valid1 = 1'b1; in_data1 = 32'h0000_00E2; out_ready1 = 1'b0;
        tick();
        chk("rstflush.pre_occ", DW'(occ1), DW'(2'd1));
        reset = 1'b1; flush1 = 1'b1;
        tick();
        reset = 1'b0; flush1 = 1'b0; in_valid1 = 1'b0;
        chk_empty1("rstflush");

        // 6: SKID=0, stale data retained; in_ready tracks out_ready combinationally
        in_valid0 = 1'b1; in_data0 = 32'h0000_0010; out_ready0 = 1'b1;
        #1;
        chk("s0.rdy_empty", DW'(in_ready0), DW'(1'b1));
        tick();
        chk("s0.first", out_data0, 32'h0000_0010);
        in_data0 = 32'h0000_0011; out_ready0 = 1'b0;
        #1;
        chk("s0.rdy_stall", DW'(in_ready0), DW'(1'b0));
        tick();
        chk("s0.held", out_data0, 32'h0000_0010);
        chk("s0.occ_held", DW'(occ0), DW'(2'd1));
        out_ready0 = 1'b1;
        #1;
        chk("s0.rdy_go", DW'(in_ready0), DW'(1'b1));
        tick();
        chk("s0.second", out_data0, 32'h0000_0011);
        in_valid0 = 1'b0;
        tick();
        chk("s0.drain_vld",   DW'(out_valid0), DW'(1'b0));
        chk("s0.stale_data",  out_data0,       32'h0000_0011);
        chk("s0.drain_occ",   DW'(occ0),       DW'(2'd0));
        chk("s0.drain_rdy",   DW'(in_ready0),  DW'(1'b1));

        // Random valid/ready scoreboard on both instances
        seq1 = 32'h0000_1000; seq0 = 32'h0000_2000;
        for (int c = 0; c < 1500; c++) begin
            in_valid1 = ($urandom_range(0, 3) != 0); out_ready1 = ($urandom_range(0, 2) != 0);
            in_valid0 = ($urandom_range(0, 3) != 0); out_ready0 = ($urandom_range(0, 2) != 0);
            in_data1 = seq1; in_data0 = seq0;
            #1;
            chk("rnd1.occ", DW'(occ1), DW'(q1.size()));
            chk("rnd0.occ", DW'(occ0), DW'(q0.size()));
            fi1 = in_valid1 & in_ready1; fo1 = out_valid1 & out_ready1;
            fi0 = in_valid0 & in_ready0; fo0 = out_valid0 & out_ready0;
            if (fo1) begin
                exp_v = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD_BEEF;
                chk("rnd1.data", out_data1, exp_v);
            end
            if (fo0) begin
                exp_v = (q0.size() > 0) ? q0.pop_front() : 32'hDEAD_BEEF;
                chk("rnd0.data", out_data0, exp_v);
            end
            if (fi1) begin q1.push_back(seq1); seq1 = seq1 + 32'd1; end
            if (fi0) begin q0.push_back(seq0); seq0 = seq0 + 32'd1; end
            tick();
        end

        // Bounded drain: both stages must empty within 4 cycles
        in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready1 = 1'b1; out_ready0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid1) begin
                exp_v = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD_BEEF;
                chk("drain1.data", out_data1, exp_v);
            end
            if (out_valid0) begin
                exp_v = (q0.size() > 0) ? q0.pop_front() : 32'hDEAD_BEEF;
                chk("drain0.data", out_data0, exp_v);
            end
            tick();
        end
        chk("drain1.empty", DW'(out_valid1), DW'(1'b0));
        chk("drain0.empty", DW'(out_valid0), DW'(1'b0));
        chk("drain1.q",     DW'(q1.size()),  DW'(0));
        chk("drain0.q",     DW'(q0.size()),  DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
